// File: rtl/character_design_loader.sv
// Assembles index + ROWS row bytes into a bit-reversed design word and commits it with a one-cycle write strobe.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module character_design_loader #(
  parameter int ROWS        = 10,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             in_data,
  input  logic                   in_first,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   design_we,
  output logic [INDEX_WIDTH-1:0] design_addr,
  output logic [8*ROWS-1:0]      design_data,
  output logic                   frame_error,
  output logic [15:0]            designs_written
);

  localparam int DW = 8 * ROWS;
  localparam int RW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROWS  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 2'd3,
`endif
    S_WRITE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [INDEX_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]          data_q, data_d;
  logic [15:0]            count_q, count_d;
  logic                   error_q, error_d;
  logic                   accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  // The generator reads the leftmost pixel from the lowest bit of each row.
  function automatic logic [7:0] reverse_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_first) begin
            state_d = S_ROWS;
            addr_d  = in_data[INDEX_WIDTH-1:0];
            row_d   = '0;
            data_d  = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = in_data;
`endif
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_ROWS: begin
        if (accept) begin
          if (in_first) begin
            error_d = 1'b1;
            addr_d  = in_data[INDEX_WIDTH-1:0];
            row_d   = '0;
            data_d  = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = in_data;
`endif
          end else begin
            for (int r = 0; r < ROWS; r++) begin
              if (row_q == RW'(r)) begin
                data_d[8*r +: 8] = reverse_byte(in_data);
              end
            end
            row_d = row_q + RW'(1);
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q ^ in_data;
            if (row_q == RW'(ROWS - 1)) begin
              state_d = S_CHECK;
            end
`else
            if (row_q == RW'(ROWS - 1)) begin
              state_d = S_WRITE;
            end
`endif
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (in_first) begin
            error_d = 1'b1;
            state_d = S_ROWS;
            addr_d  = in_data[INDEX_WIDTH-1:0];
            row_d   = '0;
            data_d  = '0;
            csum_d  = in_data;
          end else if (in_data == csum_q) begin
            state_d = S_WRITE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif

      S_WRITE: begin
        count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Gated by reset_n so the source never sees ready while the loader is held in reset.
  assign in_ready        = reset_n & (state_q != S_WRITE);
  assign design_we       = (state_q == S_WRITE);
  assign design_addr     = addr_q;
  assign design_data     = data_q;
  assign frame_error     = error_q;
  assign designs_written = count_q;

endmodule

// File: doc/character_design_loader.md
Name: character_design_loader

Overview:
- Write-side counterpart of the character generator: receives redefinable character designs as a byte stream and writes complete 80-bit designs into the character design memory.
- Each frame is one index byte followed by ROWS row bytes.
- The frame is assembled into the storage bit layout the generator reads, then committed with a single-cycle write strobe.
- Sits between the host/command decoder (byte source) and the write port of the design RAM.

Parameters:
- ROWS, 10, rows per character design; design word width = 8*ROWS.
- INDEX_WIDTH, 8, width of the character index, max 8; upper bits of the index byte are ignored.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- in_data  input  8  stream byte
- in_first  input  1  marks in_data as the index byte starting a frame
- in_valid  input  1  byte present
- in_ready  output  1  loader can accept a byte
- design_we  output  1  one-cycle write strobe to design RAM
- design_addr  output  INDEX_WIDTH  character index to write
- design_data  output  8*ROWS  assembled design word
- frame_error  output  1  one-cycle pulse on protocol violation
- designs_written  output  16  count of committed designs

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-low `reset_n`. A byte is accepted on any edge where in_valid & in_ready.
- Reset values: state=IDLE, in_ready=0 during reset and 1 from the first cycle after release, design_we=0, design_addr=0, design_data=0, frame_error=0, designs_written=0, row counter=0.
- IDLE (in_ready=1):
  - Accepted byte with in_first=1: latch design_addr=in_data[INDEX_WIDTH-1:0], clear row counter and assembly register, go to ROWS.
  - Accepted byte with in_first=0: discard it, pulse frame_error, stay in IDLE.
- ROWS (in_ready=1):
  - Accepted byte with in_first=0: store as row r = row counter, then increment.
  - Storage layout: the byte is given in display order, MSB = leftmost pixel. It is stored bit-reversed in bits [8r+7:8r], so in_data[7] lands at bit 8r+0 and in_data[0] at bit 8r+7. Row 0 is the top row and occupies bits [7:0].
  - On accepting row ROWS-1, go to WRITE (or CHECK with the optional feature).
  - Accepted byte with in_first=1 mid-frame: pulse frame_error, abandon the partial frame (no write), restart with the new index, stay in ROWS with the row counter at 0.
- WRITE (in_ready=0): design_we=1 for exactly one cycle; design_addr and design_data hold the frame. Increment designs_written, wrapping 0xFFFF→0. Return to IDLE.
- Latency: design_we is asserted on the cycle after the last row byte is accepted.
- Throughput: one frame per ROWS+2 cycles (index, rows, write).
- Output stability: design_addr and design_data stay stable from the WRITE cycle until the next frame's index byte is accepted. design_data also holds between writes.
- Stalls: in_valid low inserts stall cycles in any state; there is no timeout.
- Reset mid-frame: the partial frame is discarded, no write, counters cleared.
- frame_error is a registered one-cycle pulse, asserted the cycle after the offending byte is accepted.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - After row ROWS-1 the FSM enters CHECK (in_ready=1) and expects one more byte with in_first=0.
  - Expected value: the XOR of the index byte (full 8 bits) and all row bytes, as received (before bit reversal).
  - Match → WRITE.
  - Mismatch → pulse frame_error, no write, designs_written unchanged, go to IDLE.
  - in_first=1 in CHECK behaves like a mid-frame restart: error pulse, then ROWS with the new index.
- When undefined: no CHECK state; the frame is index + ROWS bytes and is written unconditionally.

Test Plan:
- Reset, then frame idx=0x41 with rows 0x80,0x00..0x00,0x01 (no stalls) → design_we one cycle after the last row; design_addr=0x41; design_data[0]=1, design_data[79]=1, all other bits 0; designs_written=1.
- Same frame with in_valid toggled every other cycle → identical write, no frame_error, design_we exactly one cycle.
- Byte 0x55 with in_first=0 in IDLE → frame_error pulse, no write; the following valid frame idx=0x02 writes normally.
- in_first=1 idx=0x10 at row 4 of a frame for idx=0x05, followed by 10 rows → one frame_error, single write to addr 0x10, no write to 0x05.
- reset_n low for 1 cycle at row 7 → no design_we, designs_written=0, in_ready=1 the cycle after reset release.
- LOADER_CHECKSUM_EN: idx=0x03 with rows 0x01..0x0A, checksum 0x03^0x01^…^0x0A → write. Checksum off by one bit → frame_error, no write.
